// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encoding and saturating update.
package bp_pkg;

  localparam int CTR_W = 2;

  typedef enum logic [CTR_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Step one position toward the resolved direction; both ends hold.
  function automatic ctr_t ctr_update(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: valid/tag/target array, same-cycle lookup.
// Latency: lookup combinational; a write becomes visible the cycle after (read-before-write).
// Backpressure: none, one write accepted every cycle.
module bp_btb #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TOP_B = IDX_W + 2 + TAG_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[IDX_W+2 +: TAG_W];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[IDX_W+2 +: TAG_W];

  assign rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_target = targets[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]    <= wr_tag;
      targets[wr_idx] <= wr_target;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[1:0], rd_pc[31:TOP_B], wr_pc[1:0], wr_pc[31:TOP_B]};

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor (2-bit BHT) with direct-mapped BTB; BP_GSHARE_EN enables history hashing, else bimodal.
// Latency: prediction combinational in the fetch cycle; updates land at the next edge; mispredict registered (+1).
// Backpressure: none, a lookup and an update are accepted every cycle.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int BHT_ENTRIES = 64,
  parameter int GHR_W       = 6,
  parameter int TAG_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  input  logic [GHR_W-1:0] upd_ghr,
  output logic             mispredict
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

  ctr_t bht [BHT_ENTRIES];

  logic                 btb_hit;
  logic [31:0]          btb_target;
  logic [BHT_IDX_W-1:0] fetch_idx, upd_idx;
  ctr_t                 fetch_ctr;
  logic                 mispredict_now;

  bp_btb #(
    .ENTRIES (BTB_ENTRIES),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (fetch_pc),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (upd_valid && upd_taken),
    .wr_pc     (upd_pc),
    .wr_target (upd_target)
  );

  assign mispredict_now = upd_valid &&
                          ((upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target)));

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;
  logic [GHR_W:0]   ghr_restore_full, ghr_shift_full;

  assign fetch_idx = fetch_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);
  assign upd_idx   = upd_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(upd_ghr);
  assign pred_ghr  = ghr;

  // The extra top bit falls off, which also handles a 1-bit history.
  assign ghr_restore_full = {upd_ghr, upd_taken};
  assign ghr_shift_full   = {ghr, pred_taken};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (mispredict_now) begin
      ghr <= ghr_restore_full[GHR_W-1:0];
    end else if (fetch_valid && btb_hit) begin
      ghr <= ghr_shift_full[GHR_W-1:0];
    end
  end
`else
  assign fetch_idx = fetch_pc[BHT_IDX_W+1:2];
  assign upd_idx   = upd_pc[BHT_IDX_W+1:2];
  assign pred_ghr  = '0;

  logic unused_upd_ghr;
  assign unused_upd_ghr = ^upd_ghr;
`endif

  assign fetch_ctr   = bht[fetch_idx];
  assign pred_taken  = btb_hit && fetch_ctr[1];
  assign pred_target = pred_taken ? btb_target : (fetch_pc + 32'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= WNT;
      end
    end else if (upd_valid) begin
      bht[upd_idx] <= ctr_update(bht[upd_idx], upd_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict <= 1'b0;
    end else begin
      mispredict <= mispredict_now;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare; history tests run when BP_GSHARE_EN is defined, bimodal tests otherwise.
module tb_branch_predictor_gshare;

`ifdef BP_GSHARE_EN
  localparam int BHT_N = 64;
  localparam int GHR_N = 6;
`else
  localparam int BHT_N = 16;
  localparam int GHR_N = 4;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [GHR_N-1:0] pred_ghr;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_pred_taken;
  logic [31:0]      upd_pred_target;
  logic [GHR_N-1:0] upd_ghr;
  logic             mispredict;

  int errors = 0;
  int checks = 0;

  branch_predictor_gshare #(
    .BTB_ENTRIES (16),
    .BHT_ENTRIES (BHT_N),
    .GHR_W       (GHR_N),
    .TAG_W       (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .pred_ghr        (pred_ghr),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .upd_ghr         (upd_ghr),
    .mispredict      (mispredict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid     = 1'b0;
    fetch_pc        = 32'h0;
    upd_valid       = 1'b0;
    upd_pc          = 32'h0;
    upd_taken       = 1'b0;
    upd_target      = 32'h0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h0;
    upd_ghr         = '0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt, input logic [GHR_N-1:0] g);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    upd_ghr         = g;
  endtask

  task automatic set_fetch(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    // Traffic during reset must be ignored.
    set_fetch(32'h100);
    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, '0);
    tick();
    tick();
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL reset_mispredict got=%0b want=0", mispredict);
    end
    checks++;
    if (pred_ghr !== '0) begin
      errors++;
      $display("FAIL reset_pred_ghr got=%0h want=0", pred_ghr);
    end
    idle();
    rst = 1'b0;
    set_fetch(32'h100);
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL first_lookup_taken got=%0b want=0", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h104) begin
      errors++;
      $display("FAIL first_lookup_target got=%0h want=104", pred_target);
    end
    tick();
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_mispredict got=%0b want=0", mispredict);
    end
    idle();
  endtask

  // Update/mispredict detection is the same in both builds; pc 0x400 region is not fetched.
  task automatic test_mispredict();
    logic        tk   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] tgt  [5] = '{32'h200, 32'h200, 32'h200, 32'h0, 32'h300};
    logic        ptk  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ptgt [5] = '{32'h200, 32'h204, 32'h200, 32'h500, 32'h300};
    logic        exp  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      set_upd(32'h400 + 32'(i * 4), tk[i], tgt[i], ptk[i], ptgt[i], '0);
      tick();
      idle();
      checks++;
      if (mispredict !== exp[i]) begin
        errors++;
        $display("FAIL mispredict_case%0d got=%0b want=%0b", i, mispredict, exp[i]);
      end
      tick();
      checks++;
      if (mispredict !== 1'b0) begin
        errors++;
        $display("FAIL mispredict_pulse%0d got=%0b want=0", i, mispredict);
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    set_upd(32'h480, 1'b1, 32'h600, 1'b0, 32'h484, '0);
    tick();
    checks++;
    if (mispredict !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got=%0b want=1", mispredict);
    end
    set_upd(32'h484, 1'b0, 32'h0, 1'b1, 32'h700, '0);
    tick();
    checks++;
    if (mispredict !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got=%0b want=1", mispredict);
    end
    set_upd(32'h488, 1'b0, 32'h0, 1'b0, 32'h48c, '0);
    tick();
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL b2b_third got=%0b want=0", mispredict);
    end
    idle();
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_ghr_restore();
    reset_dut();
    // Correct taken update fills the BTB for 0x100 without touching history.
    set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, '0);
    tick();
    // Not-taken mispredict restores history to {0x15,0} = 0x2A.
    set_upd(32'h180, 1'b0, 32'h0, 1'b1, 32'h200, 6'h15);
    tick();
    idle();
    #1;
    checks++;
    if (pred_ghr !== 6'h2A) begin
      errors++;
      $display("FAIL ghr_setup got=%0h want=2a", pred_ghr);
    end
    // Fetch hit and restoring mispredict in the same cycle: restore wins.
    set_fetch(32'h100);
    set_upd(32'h184, 1'b1, 32'h300, 1'b0, 32'h188, 6'h15);
    tick();
    idle();
    checks++;
    if (mispredict !== 1'b1) begin
      errors++;
      $display("FAIL ghr_restore_mispredict got=%0b want=1", mispredict);
    end
    checks++;
    if (pred_ghr !== 6'h2B) begin
      errors++;
      $display("FAIL ghr_restore got=%0h want=2b", pred_ghr);
    end
    // Hit on 0x100 with index 0x2B (weakly not-taken) shifts in a 0.
    set_fetch(32'h100);
    tick();
    idle();
    checks++;
    if (pred_ghr !== 6'h16) begin
      errors++;
      $display("FAIL ghr_shift got=%0h want=16", pred_ghr);
    end
    // Tag mismatch at the same BTB index: no shift.
    set_fetch(32'h1000);
    tick();
    idle();
    checks++;
    if (pred_ghr !== 6'h16) begin
      errors++;
      $display("FAIL ghr_no_shift_on_miss got=%0h want=16", pred_ghr);
    end
  endtask
`else
  task automatic test_first_update();
    reset_dut();
    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, '0);
    tick();
    idle();
    set_fetch(32'h100);
    #1;
    checks++;
    if (mispredict !== 1'b1) begin
      errors++;
      $display("FAIL first_update_mispredict got=%0b want=1", mispredict);
    end
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL first_update_taken got=%0b want=1", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h200) begin
      errors++;
      $display("FAIL first_update_target got=%0h want=200", pred_target);
    end
    checks++;
    if (pred_ghr !== '0) begin
      errors++;
      $display("FAIL first_update_ghr got=%0h want=0", pred_ghr);
    end
    tick();
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL first_update_pulse_end got=%0b want=0", mispredict);
    end
    idle();
  endtask

  // Counter walk WT ST ST ST WT WNT SNT SNT, observed through the direction bit.
  task automatic test_counter_seq();
    logic exp_tk;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      set_upd(32'h100, (i < 4), 32'h200, (i < 4), 32'h200, '0);
      tick();
      idle();
      set_fetch(32'h100);
      #1;
      exp_tk = (i < 5);
      checks++;
      if (pred_taken !== exp_tk) begin
        errors++;
        $display("FAIL ctr_seq%0d_taken got=%0b want=%0b", i, pred_taken, exp_tk);
      end
      checks++;
      if (pred_target !== (exp_tk ? 32'h200 : 32'h104)) begin
        errors++;
        $display("FAIL ctr_seq%0d_target got=%0h want=%0h", i, pred_target,
                 exp_tk ? 32'h200 : 32'h104);
      end
      idle();
    end
  endtask

  // Continues from SNT left by test_counter_seq.
  task automatic test_same_cycle();
    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, '0);
    tick();
    set_fetch(32'h100);
    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, '0);
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_old got=%0b want=0", pred_taken);
    end
    tick();
    idle();
    set_fetch(32'h100);
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_new got=%0b want=1", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h200) begin
      errors++;
      $display("FAIL same_cycle_new_target got=%0h want=200", pred_target);
    end
    idle();
  endtask

  // 0x100 and 0x140 share BHT index 0 with 16 entries; BTB holds whichever was taken last.
  task automatic test_bimodal_share();
    reset_dut();
    set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, '0);
    tick();
    set_upd(32'h140, 1'b1, 32'h300, 1'b1, 32'h300, '0);
    tick();
    idle();
    set_fetch(32'h140);
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      errors++;
      $display("FAIL share_strong got=%0b/%0h want=1/300", pred_taken, pred_target);
    end
    set_fetch(32'h100);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL share_tag_miss got=%0b/%0h want=0/104", pred_taken, pred_target);
    end
    idle();
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 4'hF);
    tick();
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 4'hA);
    tick();
    idle();
    set_fetch(32'h140);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
      errors++;
      $display("FAIL share_weakened got=%0b/%0h want=0/144", pred_taken, pred_target);
    end
    checks++;
    if (pred_ghr !== '0) begin
      errors++;
      $display("FAIL share_ghr got=%0h want=0", pred_ghr);
    end
    idle();
  endtask
`endif

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_mispredict();
    test_back_to_back();
`ifdef BP_GSHARE_EN
    test_ghr_restore();
`else
    test_first_update();
    test_counter_seq();
    test_same_cycle();
    test_bimodal_share();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries (power of 2, >=2).
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, number of 2-bit counters (power of 2, >=2).
REQ-003 SHALL have parameter GHR_W, default 6, global history length in bits (1..log2(BHT_ENTRIES)).
REQ-004 SHALL have parameter TAG_W, default 8, BTB tag width.
REQ-005 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-006 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- fetch_valid  in  1  fetch lookup request
- fetch_pc  in  32  fetch PC
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- pred_ghr  out  GHR_W  history snapshot used for this prediction
- upd_valid  in  1  resolved branch from execute
- upd_pc  in  32  branch PC
- upd_taken  in  1  actual direction
- upd_target  in  32  actual taken target
- upd_pred_taken  in  1  direction predicted earlier
- upd_pred_target  in  32  target predicted earlier
- upd_ghr  in  GHR_W  pred_ghr returned with the branch
- mispredict  out  1  registered one-cycle mispredict pulse

Function
REQ-007 SHALL use BTB index fetch_pc[log2(BTB_ENTRIES)+1:2]; tag is the next TAG_W bits up; hit = valid && tag match.
REQ-008 SHALL use BHT index = fetch_pc[log2(BHT_ENTRIES)+1:2] XOR zero-extended GHR.
REQ-009 SHALL drive prediction combinationally in the same cycle: pred_taken = hit && counter[1]; pred_target = BTB target if pred_taken, else fetch_pc+4, modulo 2^32.
REQ-010 SHALL, on fetch_valid && hit, shift pred_taken into GHR LSB at the next edge; no shift on miss or when fetch_valid is low.
REQ-011 SHALL, on upd_valid, index the counter with upd_pc XOR upd_ghr and saturate it: increment if taken, decrement if not; 11 and 00 hold.
REQ-012 SHALL, on upd_valid && upd_taken, write the BTB entry as valid with tag and upd_target; not-taken updates leave the BTB unchanged.
REQ-013 SHALL flag mispredict when upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)); the mispredict pulse is high exactly the following cycle.
REQ-014 SHALL restore GHR to {upd_ghr[GHR_W-2:0], upd_taken} on mispredict; restore beats any same-cycle speculative shift.
REQ-015 SHALL make same-cycle lookup and update of the same entry read the old value (read-before-write).
REQ-016 SHALL, on same-index BTB and BHT updates, apply both in one cycle; there is no stall or back-pressure.

Reset
REQ-017 SHALL, while rst is high, clear all BTB valid bits, set all counters to 01 (weakly not-taken), set GHR to 0 and mispredict to 0.
REQ-018 SHALL ignore fetch and update inputs during reset; the first lookup after deassert misses (pred_target = fetch_pc+4).

Configuration
REQ-019 SHALL, with BP_GSHARE_EN defined, behave as REQ-008/010/014.
REQ-020 SHALL, without BP_GSHARE_EN, index the BHT by PC bits only (bimodal), hold GHR at 0, drive pred_ghr = 0 and ignore upd_ghr; mispredict detection is unchanged.

Structure
REQ-021 SHALL place the counter encoding (SNT=00, WNT=01, WT=10, ST=11), the counter width constant and the saturating-update function in shared package bp_pkg.
REQ-022 SHALL implement the tag/target/valid array with its lookup and write port as sub-module bp_btb.

Verification
REQ-023 Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-024 Update pc=0x100 with taken/target 0x200 and pred_taken=0; then fetch 0x100 -> mispredict=1 for one cycle, BTB hit, counter WT, pred_taken=1, pred_target=0x200.
REQ-025 Four taken updates on one entry, then four not-taken updates -> counter sequence WT, ST, ST, ST, WT, WNT, SNT, SNT.
REQ-026 GHR_W=6, GHR=0x2A, mispredict with upd_ghr=0x15 and upd_taken=1, plus a same-cycle fetch hit -> GHR=0x2B.
REQ-027 Same-cycle fetch and update of entry 0x100 -> prediction reflects the pre-update counter; the next cycle reflects the updated counter.
REQ-028 Build without BP_GSHARE_EN, PCs 0x100 and 0x140 with BHT_ENTRIES=16 -> same counter is shared and pred_ghr=0 throughout.
